pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage ARM-style pipeline (IF, ID, EXE, MEM, WB).
- Decides every cycle whether the PC and IF/ID hold, whether a bubble enters the ID/EX register, whether wrong-path instructions are flushed on a taken branch, and whether the whole back-end freezes while SRAM is busy.
- Keeps its own shadow copy of the EXE and MEM stage hazard info (valid, wb, dest, load, mem access), so the datapath registers need no extra taps.
- Provides saturating performance counters.

Parameters:
- FORWARDING, 1: 1 = stall only on load-use; 0 = stall on any RAW hit in EXE or MEM.
- MEM_TIMEOUT, 64: maximum consecutive SRAM wait cycles before forced release.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_src1  in  4  Rn index
- id_src2  in  4  Rm or Rd-for-store index
- id_use_src1  in  1  instruction reads Rn
- id_use_src2  in  1  instruction reads src2
- id_wb_en  in  1  ID instruction writes back
- id_mem_read  in  1  ID instruction is a load
- id_mem_write  in  1  ID instruction is a store
- id_dest  in  4  destination register
- exe_branch_taken  in  1  branch resolved taken in EXE
- sram_ready  in  1  SRAM completes the MEM-stage access this cycle
- pc_freeze  out  1  hold PC
- ifid_freeze  out  1  hold IF/ID register
- ifid_flush  out  1  clear IF/ID register at next posedge
- idex_flush  out  1  load zeros (bubble) into ID/EX at next posedge
- back_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers
- hazard  out  1  RAW stall active this cycle
- mem_timeout  out  1  sticky: an SRAM wait hit MEM_TIMEOUT
- stall_cnt  out  CNT_W  RAW stall cycles, saturating
- flush_cnt  out  CNT_W  branch flush events, saturating
- freeze_cnt  out  CNT_W  SRAM freeze cycles, saturating

Behaviour:
- Reset state: shadow EXE/MEM entries invalid; FSM in M_IDLE; wait counter 0; mem_timeout 0; all counters 0. Every control output is 0 while rst is high.
- Shadow advance: on posedge, unless back_freeze is high, MEM <= EXE.
  - EXE <= zero entry if idex_flush is high; otherwise EXE <= {id_valid & ~pc_freeze, id_wb_en, id_dest, id_mem_read, id_mem_read | id_mem_write}.
- RAW hit: an entry is valid, has wb set, and its dest equals a used source (id_src1 when id_use_src1, id_src2 when id_use_src2). Only checked when id_valid is high.
  - FORWARDING=1: raw = hit against EXE where EXE.load is set.
  - FORWARDING=0: raw = hit against EXE or MEM.
- Memory FSM:
  - M_IDLE -> M_WAIT when MEM.mem_access is set and sram_ready is low.
  - M_WAIT -> M_IDLE on sram_ready, or when the wait count reaches MEM_TIMEOUT-1. The timeout exit sets mem_timeout (sticky until rst).
  - Wait counter clears on entry to M_WAIT and increments each cycle in M_WAIT.
- Freeze: mem_freeze is combinational = MEM.mem_access & ~sram_ready & ~timeout_release.
- Output priority, evaluated combinationally each cycle:
  1. mem_freeze: back_freeze=pc_freeze=ifid_freeze=1; no flush outputs; hazard=0.
  2. exe_branch_taken: ifid_flush=idex_flush=1; no freezes; hazard=0.
  3. raw: pc_freeze=ifid_freeze=idex_flush=1; hazard=1.
  4. Otherwise all outputs 0.
- Simultaneous events:
  - A branch during mem_freeze is deferred. EXE holds, so the branch reasserts once the freeze ends.
  - A branch together with raw counts as a flush only.
- Latency: the decision is 0-cycle combinational from inputs and shadow state; shadow state updates one posedge later.
- Counters: stall_cnt increments on each raw cycle (priority 3). flush_cnt increments once per flush cycle. freeze_cnt increments on each mem_freeze cycle. All saturate at all-ones.
- Reset mid-freeze or mid-stall: everything returns to the reset state immediately; no pending flush survives.

Decomposition:
- Shared package pipe_pkg:
  - hazard-entry struct {valid, wb, dest[3:0], load, mem_access}
  - memory FSM state enum {M_IDLE, M_WAIT}
  - register index width constant (4)
- One sub-module, sat_counter (parameter CNT_W; inputs inc, rst, clk), instantiated three times.

Test Plan:
1. Load-use, FORWARDING=1: LDR R1 reaches EXE while ID holds ADD R2,R1,R3 -> one cycle with hazard=pc_freeze=ifid_freeze=idex_flush=1, then clear; stall_cnt=1.
2. ALU RAW, FORWARDING=0: ADD R4 in MEM, ID SUB R5,R4,R6 -> hazard high for 1 cycle. Same case with FORWARDING=1 -> hazard never high.
3. Taken branch alone, and taken branch together with a load-use -> ifid_flush=idex_flush=1 for exactly 1 cycle; flush_cnt=1; stall_cnt unchanged.
4. SRAM wait: store in MEM, sram_ready low for 5 cycles -> back_freeze high exactly 5 cycles; freeze_cnt=5; shadow MEM unchanged throughout.
5. Timeout, MEM_TIMEOUT=8: sram_ready held low -> freeze for 8 cycles, then released; mem_timeout=1 and stays 1 until rst.
6. Assert rst during an SRAM freeze -> all outputs 0 and counters 0 asynchronously; first post-reset instruction sees no hazard.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline sequencing controller: shadow hazard entry,
// memory-wait FSM states and the register-index width.
package pipe_pkg;

  localparam int unsigned REG_W = 4;

  typedef struct packed {
    logic             valid;
    logic             wb;
    logic [REG_W-1:0] dest;
    logic             load;
    logic             mem_access;
  } haz_entry_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

  // True when a live writer in a later stage targets a source that ID actually reads.
  function automatic logic src_hit(input haz_entry_t e,
                                   input logic [REG_W-1:0] src1,
                                   input logic [REG_W-1:0] src2,
                                   input logic use1,
                                   input logic use2);
    return e.valid & e.wb & ((use1 & (e.dest == src1)) | (use2 & (e.dest == src2)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones once full.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stalls, branch flushes and SRAM-wait
// freezes decided combinationally from ID inputs and a private EXE/MEM shadow.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FORWARDING  = 1,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic [REG_W-1:0] id_dest,
  input  logic             exe_branch_taken,
  input  logic             sram_ready,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             back_freeze,
  output logic             hazard,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  haz_entry_t        exe_q, mem_q, exe_d;
  mem_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_release, timeout_set;
  logic              mem_freeze, exe_hit, mem_hit, raw;

  // Entry the ID instruction would occupy in EXE after this edge.
  always_comb begin
    exe_d            = '0;
    exe_d.valid      = id_valid & ~pc_freeze;
    exe_d.wb         = id_wb_en;
    exe_d.dest       = id_dest;
    exe_d.load       = id_mem_read;
    exe_d.mem_access = id_mem_read | id_mem_write;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
    end else if (!back_freeze) begin
      mem_q <= exe_q;
      exe_q <= idex_flush ? '0 : exe_d;
    end
  end

  assign exe_hit = id_valid & src_hit(exe_q, id_src1, id_src2, id_use_src1, id_use_src2);
  assign mem_hit = id_valid & src_hit(mem_q, id_src1, id_src2, id_use_src1, id_use_src2);

  generate
    if (FORWARDING != 0) begin : g_fwd
      assign raw = exe_hit & exe_q.load;
    end else begin : g_nofwd
      assign raw = exe_hit | mem_hit;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= M_IDLE;
      wait_q      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (timeout_set) mem_timeout <= 1'b1;
    end
  end

  // SRAM wait tracking; the last allowed wait cycle releases the freeze.
  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    timeout_release = 1'b0;
    timeout_set     = 1'b0;
    case (state_q)
      M_IDLE: begin
        if (mem_q.mem_access && !sram_ready) begin
          state_d = M_WAIT;
          wait_d  = '0;
        end
      end
      M_WAIT: begin
        if (sram_ready) begin
          state_d = M_IDLE;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d         = M_IDLE;
          timeout_release = 1'b1;
          timeout_set     = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
    endcase
  end

  assign mem_freeze = mem_q.mem_access & ~sram_ready & ~timeout_release;

  // Priority: SRAM freeze, then branch flush, then RAW stall.
  always_comb begin
    pc_freeze   = 1'b0;
    ifid_freeze = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    back_freeze = 1'b0;
    hazard      = 1'b0;
    if (!rst) begin
      if (mem_freeze) begin
        back_freeze = 1'b1;
        pc_freeze   = 1'b1;
        ifid_freeze = 1'b1;
      end else if (exe_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (raw) begin
        pc_freeze   = 1'b1;
        ifid_freeze = 1'b1;
        idex_flush  = 1'b1;
        hazard      = 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(hazard), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(ifid_flush), .cnt(flush_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk(clk), .rst(rst), .inc(back_freeze), .cnt(freeze_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: a FORWARDING=1 and a FORWARDING=0 controller share the same
// directed cycle vectors; expected responses are queued and checked at negedge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 16;

  localparam logic [5:0] NONE = 6'b000000; // {pcf, ifidf, ifidfl, idexfl, backf, haz}
  localparam logic [5:0] RAW  = 6'b110101;
  localparam logic [5:0] BR   = 6'b001100;
  localparam logic [5:0] FRZ  = 6'b110010;

  typedef struct packed {
    logic       rs;
    logic       v;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       u1;
    logic       u2;
    logic       wb;
    logic       rd;
    logic       wr;
    logic [3:0] d;
    logic       br;
    logic       rdy;
  } vec_t;

  typedef struct packed {
    logic [5:0]       c1;
    logic             h0;
    logic             chk;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] fl;
    logic [CNT_W-1:0] fz;
    logic             mto;
  } exp_t;

  logic clk, rst;
  logic id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_read, id_mem_write;
  logic [3:0] id_src1, id_src2, id_dest;
  logic exe_branch_taken, sram_ready;

  logic pcf1, ifidf1, ifidfl1, idexfl1, backf1, haz1, mto1;
  logic [CNT_W-1:0] st1, fl1, fz1;
  logic f0_unused_pcf, f0_unused_ifidf, f0_unused_ifidfl, f0_unused_idexfl, f0_unused_backf;
  logic haz0, f0_unused_mto;
  logic [CNT_W-1:0] f0_unused_st, f0_unused_fl, f0_unused_fz;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int n = 0;

  pipe_hazard_ctrl #(.FORWARDING(1), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_dest(id_dest),
    .exe_branch_taken(exe_branch_taken), .sram_ready(sram_ready),
    .pc_freeze(pcf1), .ifid_freeze(ifidf1), .ifid_flush(ifidfl1), .idex_flush(idexfl1),
    .back_freeze(backf1), .hazard(haz1), .mem_timeout(mto1),
    .stall_cnt(st1), .flush_cnt(fl1), .freeze_cnt(fz1)
  );

  pipe_hazard_ctrl #(.FORWARDING(0), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_dest(id_dest),
    .exe_branch_taken(exe_branch_taken), .sram_ready(sram_ready),
    .pc_freeze(f0_unused_pcf), .ifid_freeze(f0_unused_ifidf), .ifid_flush(f0_unused_ifidfl),
    .idex_flush(f0_unused_idexfl), .back_freeze(f0_unused_backf), .hazard(haz0),
    .mem_timeout(f0_unused_mto), .stall_cnt(f0_unused_st), .flush_cnt(f0_unused_fl),
    .freeze_cnt(f0_unused_fz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t ins(input logic [3:0] s1, input logic [3:0] s2, input logic u1,
                               input logic u2, input logic wb, input logic rd, input logic wr,
                               input logic [3:0] d, input logic br);
    vec_t x;
    x = '{rs: 1'b0, v: 1'b1, s1: s1, s2: s2, u1: u1, u2: u2, wb: wb, rd: rd, wr: wr,
          d: d, br: br, rdy: 1'b1};
    return x;
  endfunction

  function automatic vec_t idle(input logic rdy, input logic br, input logic rs);
    vec_t x;
    x = '0;
    x.rdy = rdy;
    x.br  = br;
    x.rs  = rs;
    return x;
  endfunction

  function automatic exp_t ex(input logic [5:0] c, input logic h0);
    exp_t e;
    e = '0;
    e.c1 = c;
    e.h0 = h0;
    return e;
  endfunction

  function automatic exp_t exc(input logic [5:0] c, input logic h0, input int st,
                               input int fl, input int fz, input logic mto);
    exp_t e;
    e = ex(c, h0);
    e.chk = 1'b1;
    e.st  = CNT_W'(st);
    e.fl  = CNT_W'(fl);
    e.fz  = CNT_W'(fz);
    e.mto = mto;
    return e;
  endfunction

  // Apply one cycle of inputs just after the edge and queue what must be seen.
  task automatic step(input vec_t x, input exp_t e);
    rst              = x.rs;
    id_valid         = x.v;
    id_src1          = x.s1;
    id_src2          = x.s2;
    id_use_src1      = x.u1;
    id_use_src2      = x.u2;
    id_wb_en         = x.wb;
    id_mem_read      = x.rd;
    id_mem_write     = x.wr;
    id_dest          = x.d;
    exe_branch_taken = x.br;
    sram_ready       = x.rdy;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e = sbq.pop_front();
      n++;
      act = {pcf1, ifidf1, ifidfl1, idexfl1, backf1, haz1};
      total++;
      if (act !== e.c1) begin
        bad++;
        $display("FAIL ctrl step %0d: got %b want %b", n, act, e.c1);
      end
      total++;
      if (haz0 !== e.h0) begin
        bad++;
        $display("FAIL nofwd_hazard step %0d: got %b want %b", n, haz0, e.h0);
      end
      if (e.chk) begin
        total++;
        if ({st1, fl1, fz1, mto1} !== {e.st, e.fl, e.fz, e.mto}) begin
          bad++;
          $display("FAIL counters step %0d: got st=%0d fl=%0d fz=%0d mto=%b want st=%0d fl=%0d fz=%0d mto=%b",
                   n, st1, fl1, fz1, mto1, e.st, e.fl, e.fz, e.mto);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_use_src1 = 1'b0; id_use_src2 = 1'b0;
    id_wb_en = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_dest = '0;
    exe_branch_taken = 1'b0; sram_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    step(idle(1, 0, 0), exc(NONE, 0, 0, 0, 0, 0));

    // Load-use: LDR R1 then ADD R2,R1,R3
    step(ins(0, 0, 1, 0, 1, 1, 0, 1, 0), ex(NONE, 0));
    step(ins(1, 3, 1, 1, 1, 0, 0, 2, 0), ex(RAW, 1));
    step(ins(1, 3, 1, 1, 1, 0, 0, 2, 0), ex(NONE, 1));
    step(idle(1, 0, 0), ex(NONE, 0));
    step(idle(1, 0, 0), exc(NONE, 0, 1, 0, 0, 0));

    // ALU RAW against MEM: ADD R4, bubble, SUB R5,R4,R6
    step(ins(7, 8, 1, 1, 1, 0, 0, 4, 0), ex(NONE, 0));
    step(idle(1, 0, 0), ex(NONE, 0));
    step(ins(4, 6, 1, 1, 1, 0, 0, 5, 0), ex(NONE, 1));
    step(idle(1, 0, 0), ex(NONE, 0));
    step(idle(1, 0, 0), exc(NONE, 0, 1, 0, 0, 0));

    // Taken branch alone, then branch coinciding with a load-use
    step(ins(10, 11, 1, 1, 1, 0, 0, 9, 1), ex(BR, 0));
    step(idle(1, 0, 0), ex(NONE, 0));
    step(idle(1, 0, 0), exc(NONE, 0, 1, 1, 0, 0));
    step(ins(0, 0, 1, 0, 1, 1, 0, 3, 0), ex(NONE, 0));
    step(ins(3, 3, 1, 1, 1, 0, 0, 2, 1), ex(BR, 0));
    step(idle(1, 0, 0), ex(NONE, 0));
    step(idle(1, 0, 0), exc(NONE, 0, 1, 2, 0, 0));

    // Store waits 5 cycles on SRAM; a branch during the freeze is deferred
    step(ins(6, 5, 1, 1, 0, 0, 1, 0, 0), ex(NONE, 0));
    step(idle(1, 0, 0), ex(NONE, 0));
    repeat (4) step(idle(0, 0, 0), ex(FRZ, 0));
    step(idle(0, 1, 0), ex(FRZ, 0));
    step(idle(1, 1, 0), ex(BR, 0));
    step(idle(1, 0, 0), ex(NONE, 0));
    step(idle(1, 0, 0), exc(NONE, 0, 1, 3, 5, 0));

    // SRAM never ready: 8 frozen cycles, forced release, sticky timeout
    step(ins(0, 0, 1, 0, 1, 1, 0, 1, 0), ex(NONE, 0));
    step(idle(1, 0, 0), ex(NONE, 0));
    repeat (8) step(idle(0, 0, 0), ex(FRZ, 0));
    step(idle(0, 0, 0), exc(NONE, 0, 1, 3, 13, 0));
    step(idle(0, 0, 0), exc(NONE, 0, 1, 3, 13, 1));
    step(idle(1, 0, 0), exc(NONE, 0, 1, 3, 13, 1));

    // Reset in the middle of a freeze with a pending branch and a load in EXE
    step(ins(0, 0, 1, 0, 1, 1, 0, 1, 0), ex(NONE, 0));
    step(ins(0, 0, 1, 0, 1, 1, 0, 2, 0), ex(NONE, 0));
    step(idle(0, 0, 0), ex(FRZ, 0));
    step(idle(0, 1, 0), ex(FRZ, 0));
    step(idle(0, 1, 1), exc(NONE, 0, 0, 0, 0, 0));
    step(ins(2, 2, 1, 1, 1, 0, 0, 3, 0), exc(NONE, 0, 0, 0, 0, 0));
    step(idle(1, 0, 0), ex(NONE, 0));

    repeat (2) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
